// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC/branch-resolution stage: branch codes, FSM
// encodings, ALU selector codes and the alignment helper.
package pc_branch_unit_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef logic [1:0] state_t;
  localparam state_t ST_BOOT = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_TRAP = 2'd2;

  // Instruction fetch requires word alignment; any low address bit set traps.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_branch_unit_cond.sv
// Branch-condition evaluator: maps funct3 and the flags of (a - b) to cond_true.
module branch_cond
  import pc_branch_unit_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       carry,
  input  logic       overflow,
  input  logic       negative,
  output logic       cond_true
);

  logic lt_signed;

  // carry is the no-borrow flag, so unsigned less-than is its inverse.
  always_comb begin
    lt_signed = negative ^ overflow;
    cond_true = 1'b0;
    case (funct3)
      F3_BEQ:  cond_true = zero;
      F3_BNE:  cond_true = ~zero;
      F3_BLT:  cond_true = lt_signed;
      F3_BGE:  cond_true = ~lt_signed;
      F3_BLTU: cond_true = ~carry;
      F3_BGEU: cond_true = carry;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, branch/jump resolution, misaligned-target trap and retire counter.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          XLEN         = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch,
  input  logic                   jump,
  input  logic                   jalr,
  input  logic [2:0]             funct3,
  input  logic signed [XLEN-1:0] imm,
  input  logic [XLEN-1:0]        alu_result,
  input  logic                   zero,
  input  logic                   carry,
  input  logic                   overflow,
  input  logic                   negative,
  output logic [XLEN-1:0]        pc,
  output logic [XLEN-1:0]        pc_plus4,
  output logic [XLEN-1:0]        pc_next,
  output logic                   taken,
  output logic                   instr_valid,
  output logic                   misaligned,
  output logic [XLEN-1:0]        instret
);

  state_t          state;
  logic            cond_true;
  logic            taken_raw;
  logic            in_run;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_rel;

  branch_cond u_branch_cond (
    .funct3    (funct3),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .negative  (negative),
    .cond_true (cond_true)
  );

  assign in_run   = (state == ST_RUN);
  assign pc_plus4 = pc + 32'd4;
  assign pc_rel   = pc + $unsigned(imm);

  always_comb begin
    taken_raw = 1'b0;
    target    = pc_plus4;
    if (jalr) begin
      taken_raw = 1'b1;
      target    = alu_result & ~32'd1;
    end else if (jump) begin
      taken_raw = 1'b1;
      target    = pc_rel;
    end else if (branch && cond_true) begin
      taken_raw = 1'b1;
      target    = pc_rel;
    end
  end

  // Outside RUN the fetch address is frozen and no transfer is reported.
  assign taken   = in_run & taken_raw;
  assign pc_next = in_run ? target : pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_VECTOR;
      instr_valid <= 1'b0;
      misaligned  <= 1'b0;
      instret     <= '0;
    end else begin
      case (state)
        ST_BOOT: begin
          state       <= ST_RUN;
          instr_valid <= 1'b1;
        end
        ST_RUN: begin
          if (!stall) begin
            if (taken && is_misaligned(target)) begin
              state       <= ST_TRAP;
              misaligned  <= 1'b1;
              instr_valid <= 1'b0;
            end else begin
              pc      <= pc_next;
              instret <= instret + 32'd1;
            end
          end
        end
        default: begin
          state <= ST_TRAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed-vector bench for pc_branch_unit with hand-computed expectations.
module tb_pc_branch_unit;
  logic        clk = 1'b0;
  logic        reset, stall, branch, jump, jalr;
  logic [2:0]  funct3;
  logic [31:0] imm, alu_result;
  logic        zero, carry, overflow, negative;
  logic [31:0] pc, pc_plus4, pc_next, instret;
  logic        taken, instr_valid, misaligned;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  pc_branch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .jump(jump),
    .jalr(jalr), .funct3(funct3), .imm(imm), .alu_result(alu_result),
    .zero(zero), .carry(carry), .overflow(overflow), .negative(negative),
    .pc(pc), .pc_plus4(pc_plus4), .pc_next(pc_next), .taken(taken),
    .instr_valid(instr_valid), .misaligned(misaligned), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch = 0; jump = 0; jalr = 0; funct3 = 3'b000;
    imm = 0; alu_result = 0; zero = 0; carry = 0; overflow = 0; negative = 0;
  endtask

  task automatic goto_pc(input logic [31:0] t);
    clear_inputs();
    jump = 1; imm = t - exp_pc;
    tick();
    jump = 0;
    exp_pc = t; exp_ret = exp_ret + 1;
    nvec++; if (pc !== exp_pc) begin nerr++; $display("FAIL goto pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    nvec++; if (pc !== 32'h0) begin nerr++; $display("FAIL reset pc: got %h want 0", pc); end
    nvec++; if (instr_valid !== 1'b0) begin nerr++; $display("FAIL reset instr_valid: got %b want 0", instr_valid); end
    nvec++; if (misaligned !== 1'b0) begin nerr++; $display("FAIL reset misaligned: got %b want 0", misaligned); end
    nvec++; if (instret !== 32'h0) begin nerr++; $display("FAIL reset instret: got %h want 0", instret); end
    reset = 0;
    jump = 1; imm = 32'h100;
    #1;
    nvec++; if (taken !== 1'b0) begin nerr++; $display("FAIL boot taken: got %b want 0", taken); end
    nvec++; if (pc_next !== 32'h0) begin nerr++; $display("FAIL boot pc_next: got %h want 0", pc_next); end
    tick();
    jump = 0;
    nvec++; if (instr_valid !== 1'b1) begin nerr++; $display("FAIL boot->run instr_valid: got %b want 1", instr_valid); end
    nvec++; if (pc !== 32'h0) begin nerr++; $display("FAIL boot holds pc: got %h want 0", pc); end
    exp_pc = 0; exp_ret = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = exp_pc + 4; exp_ret = exp_ret + 1;
      nvec++; if (pc !== exp_pc) begin nerr++; $display("FAIL seq pc %0d: got %h want %h", i, pc, exp_pc); end
      nvec++; if (instret !== exp_ret) begin nerr++; $display("FAIL seq instret %0d: got %h want %h", i, instret, exp_ret); end
    end
  endtask

  task automatic test_beq();
    goto_pc(32'h10);
    branch = 1; funct3 = 3'b000; zero = 1; imm = 32'hFFFF_FFF8;
    #1;
    nvec++; if (taken !== 1'b1) begin nerr++; $display("FAIL beq taken: got %b want 1", taken); end
    nvec++; if (pc_next !== 32'h8) begin nerr++; $display("FAIL beq pc_next: got %h want 8", pc_next); end
    tick();
    exp_pc = 32'h8; exp_ret = exp_ret + 1;
    nvec++; if (pc !== exp_pc) begin nerr++; $display("FAIL beq pc: got %h want %h", pc, exp_pc); end
    goto_pc(32'h10);
    branch = 1; funct3 = 3'b000; zero = 0; imm = 32'hFFFF_FFF8;
    #1;
    nvec++; if (taken !== 1'b0) begin nerr++; $display("FAIL beq-nt taken: got %b want 0", taken); end
    tick();
    exp_pc = 32'h14; exp_ret = exp_ret + 1;
    nvec++; if (pc !== exp_pc) begin nerr++; $display("FAIL beq-nt pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_compare();
    goto_pc(32'h20);
    branch = 1; imm = 32'h40;
    funct3 = 3'b100; negative = 1; overflow = 0; #1;
    nvec++; if (taken !== 1'b1 || pc_next !== 32'h60) begin nerr++; $display("FAIL blt: got %b/%h want 1/00000060", taken, pc_next); end
    funct3 = 3'b101; #1;
    nvec++; if (taken !== 1'b0 || pc_next !== 32'h24) begin nerr++; $display("FAIL bge: got %b/%h want 0/00000024", taken, pc_next); end
    negative = 0; overflow = 1; funct3 = 3'b100; #1;
    nvec++; if (taken !== 1'b1) begin nerr++; $display("FAIL blt-ovf: got %b want 1", taken); end
    overflow = 0; carry = 1; funct3 = 3'b110; #1;
    nvec++; if (taken !== 1'b0 || pc_next !== 32'h24) begin nerr++; $display("FAIL bltu: got %b/%h want 0/00000024", taken, pc_next); end
    funct3 = 3'b001; zero = 0; #1;
    nvec++; if (taken !== 1'b1) begin nerr++; $display("FAIL bne: got %b want 1", taken); end
    funct3 = 3'b010; zero = 1; #1;
    nvec++; if (taken !== 1'b0) begin nerr++; $display("FAIL f3-010: got %b want 0", taken); end
    funct3 = 3'b011; zero = 0; #1;
    nvec++; if (taken !== 1'b0) begin nerr++; $display("FAIL f3-011: got %b want 0", taken); end
    funct3 = 3'b111; carry = 1; #1;
    nvec++; if (taken !== 1'b1 || pc_next !== 32'h60) begin nerr++; $display("FAIL bgeu: got %b/%h want 1/00000060", taken, pc_next); end
    tick();
    exp_pc = 32'h60; exp_ret = exp_ret + 1;
    nvec++; if (pc !== exp_pc) begin nerr++; $display("FAIL bgeu pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    #1;
    nvec++; if (pc_plus4 !== 32'h0) begin nerr++; $display("FAIL wrap pc_plus4: got %h want 0", pc_plus4); end
    tick();
    exp_pc = 32'h0; exp_ret = exp_ret + 1;
    nvec++; if (pc !== exp_pc) begin nerr++; $display("FAIL wrap pc: got %h want 0", pc); end
  endtask

  task automatic test_jalr();
    goto_pc(32'h30);
    jalr = 1; alu_result = 32'h101; jump = 1; imm = 32'h200; #1;
    nvec++; if (taken !== 1'b1 || pc_next !== 32'h100) begin nerr++; $display("FAIL jalr: got %b/%h want 1/00000100", taken, pc_next); end
    nvec++; if (pc_plus4 !== 32'h34) begin nerr++; $display("FAIL jalr link: got %h want 00000034", pc_plus4); end
    tick();
    exp_pc = 32'h100; exp_ret = exp_ret + 1;
    nvec++; if (pc !== exp_pc) begin nerr++; $display("FAIL jalr pc: got %h want %h", pc, exp_pc); end
  endtask

  task automatic test_stall();
    goto_pc(32'h40);
    stall = 1; jump = 1; imm = 32'h100;
    for (int i = 0; i < 3; i++) begin
      tick();
      nvec++; if (pc !== 32'h40 || instret !== exp_ret) begin nerr++; $display("FAIL stall %0d: got %h/%h want 00000040/%h", i, pc, instret, exp_ret); end
    end
    stall = 0;
    tick();
    exp_pc = 32'h140; exp_ret = exp_ret + 1;
    nvec++; if (pc !== exp_pc || instret !== exp_ret) begin nerr++; $display("FAIL unstall: got %h/%h want %h/%h", pc, instret, exp_pc, exp_ret); end
  endtask

  task automatic test_trap();
    goto_pc(32'h30);
    jalr = 1; alu_result = 32'h102; #1;
    nvec++; if (taken !== 1'b1) begin nerr++; $display("FAIL trap taken: got %b want 1", taken); end
    tick();
    jalr = 0;
    nvec++; if (misaligned !== 1'b1 || instr_valid !== 1'b0) begin nerr++; $display("FAIL trap flags: got %b/%b want 1/0", misaligned, instr_valid); end
    nvec++; if (pc !== 32'h30 || instret !== exp_ret) begin nerr++; $display("FAIL trap hold: got %h/%h want 00000030/%h", pc, instret, exp_ret); end
    jump = 1; imm = 32'h8; branch = 1; zero = 1; #1;
    nvec++; if (taken !== 1'b0 || pc_next !== 32'h30) begin nerr++; $display("FAIL trap inert: got %b/%h want 0/00000030", taken, pc_next); end
    tick();
    nvec++; if (pc !== 32'h30 || misaligned !== 1'b1) begin nerr++; $display("FAIL trap sticky: got %h/%b want 00000030/1", pc, misaligned); end
    reset = 1;
    tick();
    reset = 0;
    clear_inputs();
    nvec++; if (pc !== 32'h0 || misaligned !== 1'b0 || instret !== 32'h0) begin nerr++; $display("FAIL trap reset: got %h/%b/%h want 0/0/0", pc, misaligned, instret); end
    tick();
    nvec++; if (instr_valid !== 1'b1) begin nerr++; $display("FAIL post-trap boot: got %b want 1", instr_valid); end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    exp_pc = 0; exp_ret = 0;
    test_reset();
    test_beq();
    test_compare();
    test_wrap();
    test_jalr();
    test_stall();
    test_trap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
Program-counter and branch-resolution stage that consumes the ALU's Result and Zero/Carry/Overflow/Negative flags. It decides branch/jump outcomes, holds the architectural PC, and drives the fetch address for the next cycle. It also detects misaligned control-flow targets, which halt fetch via a trap state, and keeps a retired-instruction counter.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
stall  in  1  holds the PC and the retire counter this cycle.
branch  in  1  current instruction is a conditional branch.
jump  in  1  current instruction is JAL.
jalr  in  1  current instruction is JALR.
funct3  in  3  branch condition code.
imm  in  32  sign-extended branch/JAL offset.
alu_result  in  32  ALU Result; the JALR target sum.
zero, carry, overflow, negative  in  1 each  ALU flags from the compare subtraction (a - b).
pc  out  32  registered current PC.
pc_plus4  out  32  pc + 4, combinational; the link value for JAL/JALR.
pc_next  out  32  combinational next-PC.
taken  out  1  combinational; control transfer taken this cycle.
instr_valid  out  1  registered; high when pc addresses a valid instruction.
misaligned  out  1  registered; sticky trap flag.
instret  out  32  registered retired-instruction count.

Behaviour:
- Interface is decided: one clock (clk); reset is synchronous and active-high (reset). Reset dominates all other inputs, including mid-trap and mid-stall.
- Reset values: pc=RESET_VECTOR, instr_valid=0, misaligned=0, instret=0, state=BOOT.
- FSM states and transitions:
  - BOOT: one cycle covering instruction-memory latency. instr_valid=0 and pc holds. Always moves to RUN, ignoring stall.
  - RUN: instr_valid=1. On each edge with stall=0, pc<=pc_next and instret<=instret+1; if the taken target is misaligned, the trap rule below applies instead. With stall=1, pc and instret hold.
  - TRAP: entered from RUN when taken=1, stall=0 and target[1:0]!=0. On entry, misaligned<=1 and instr_valid<=0; pc keeps the faulting instruction's address and instret does not increment. The block stays in TRAP until reset.
- Branch condition, valid only when branch=1; the flags come from ALU subtraction a - b:
  - 000 BEQ: zero.
  - 001 BNE: !zero.
  - 100 BLT: negative^overflow.
  - 101 BGE: !(negative^overflow).
  - 110 BLTU: !carry (carry=1 means no borrow, i.e. a>=u b).
  - 111 BGEU: carry.
  - 010 and 011: never taken.
- Target selection, priority jalr > jump > branch:
  - jalr: target={alu_result[31:1],1'b0}; taken=1.
  - jump: target=pc+imm; taken=1.
  - branch and condition true: target=pc+imm; taken=1.
  - otherwise: taken=0 and pc_next=pc_plus4.
- All adds are modulo 2^32: pc+imm and pc+4 wrap silently (0xFFFF_FFFC+4 = 0x0000_0000). instret wraps 0xFFFF_FFFF to 0.
- taken and pc_next are forced to 0 and pc respectively outside RUN.
- Simultaneous stall and taken: no update; the decision is re-evaluated next cycle from the then-current inputs.
- Latency: the control decision is combinational in the same cycle; the pc update is visible one edge later.

Decomposition:
- Shared package: funct3 branch codes, FSM state enum (BOOT/RUN/TRAP), RESET_VECTOR default, ALU selection codes (SUB=3'b001 for compares).
- Sub-module branch_cond: combinational mapping of funct3 plus the four flags to cond_true; reused later by the pipelined core.

Test Plan:
- Reset sequence: reset high 2 cycles, then low. Required: cycle 0 pc=0x0 with instr_valid=0; next cycle instr_valid=1; then pc=0x4, 0x8, 0xC on successive edges with instret=1,2,3.
- BEQ back: at pc=0x10, branch=1, funct3=000, zero=1, imm=-8. Required: taken=1, pc_next=0x08, pc=0x08 next edge. Same stimulus with zero=0 gives pc=0x14.
- Signed/unsigned compare at pc=0x20, imm=0x40:
  - BLT with negative=1, overflow=0: taken, target 0x60.
  - BLTU with carry=1: not taken, next pc 0x24.
  - BGEU with carry=1: taken, target 0x60.
- JALR at pc=0x30, jalr=1, alu_result=0x0000_0101. Required: target 0x100, pc_plus4=0x34, pc=0x100 next edge.
- Misaligned JALR with alu_result=0x102. Required next edge: misaligned=1, instr_valid=0, pc holds 0x30, instret frozen. Subsequent branch/jump inputs have no effect. Asserting reset restores pc=0x0 and misaligned=0.
- Stall: stall=1 for 3 cycles with jump=1 and imm=0x100 at pc=0x40. Required: pc holds 0x40 and instret holds. The cycle after stall drops, pc=0x140.
